// File: rtl/si_tag_serializer.sv
// si_tag_serializer
// Turns beats of WORD_WIDTH lane-sparse decoded tags into a stream of one
// tag per cycle, lowest lane first, with valid/ready flow control on both
// sides. Also counts delivered tags and flags any backwards step in the
// emitted timestamps (sticky until reset).
// Output fields are muxed purely from registered lane data, so there is no
// combinational path from the s_axis data inputs to the m_axis outputs.

module si_tag_serializer #(
   parameter int WORD_WIDTH = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic [WORD_WIDTH-1:0]     s_axis_tkeep,
   input  logic [5*WORD_WIDTH-1:0]   s_axis_channel,
   input  logic [64*WORD_WIDTH-1:0]  s_axis_tagtime,
   input  logic [WORD_WIDTH-1:0]     s_axis_rising_edge,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [4:0]                m_axis_channel,
   output logic [63:0]               m_axis_tagtime,
   output logic                      m_axis_rising_edge,
   output logic                      m_axis_tlast,
   output logic [CNT_WIDTH-1:0]      tag_count,
   output logic                      order_error
);

   localparam int CH_W = 5;
   localparam int TM_W = 64;

   // True when exactly one bit of the mask is set.
   function automatic logic is_single(input logic [WORD_WIDTH-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (v[i] && seen) begin
            multi = 1'b1;
         end else if (v[i]) begin
            seen = 1'b1;
         end else begin
            multi = multi;
         end
      end
      return seen & ~multi;
   endfunction

   // Registered state
   logic [WORD_WIDTH-1:0]      pending_q,    pending_d;
   logic [CH_W*WORD_WIDTH-1:0] chan_q,       chan_d;
   logic [TM_W*WORD_WIDTH-1:0] time_q,       time_d;
   logic [WORD_WIDTH-1:0]      edge_q,       edge_d;
   logic                       run_q,        run_d;
   logic [TM_W-1:0]            prev_time_q,  prev_time_d;
   logic                       prev_valid_q, prev_valid_d;
   logic [CNT_WIDTH-1:0]       count_q,      count_d;
   logic                       order_err_q,  order_err_d;

   // Combinational helpers
   logic [WORD_WIDTH-1:0]      sel_mask_s;
   logic [CH_W-1:0]            sel_ch_s;
   logic [TM_W-1:0]            sel_time_s;
   logic                       sel_edge_s;
   logic                       m_valid_s;
   logic                       m_last_s;
   logic                       m_hs_s;
   logic                       s_ready_s;
   logic                       s_hs_s;

   // Pick the lowest pending lane and mux its registered fields out;
   // all fields read zero when nothing is pending.
   always_comb begin
      logic found;
      found      = 1'b0;
      sel_mask_s = '0;
      sel_ch_s   = 5'd0;
      sel_time_s = 64'd0;
      sel_edge_s = 1'b0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (pending_q[i] && !found) begin
            sel_mask_s[i] = 1'b1;
            sel_ch_s      = chan_q[i*CH_W +: CH_W];
            sel_time_s    = time_q[i*TM_W +: TM_W];
            sel_edge_s    = edge_q[i];
            found         = 1'b1;
         end else begin
            sel_mask_s[i] = 1'b0;
         end
      end
   end

   // Handshake qualification. A new beat may enter when the holding
   // registers are empty or their last lane leaves in this same cycle.
   assign m_valid_s = |pending_q;
   assign m_last_s  = is_single(pending_q);
   assign m_hs_s    = m_valid_s & m_axis_tready;
   assign s_ready_s = run_q & (~m_valid_s | (m_hs_s & m_last_s));
   assign s_hs_s    = s_axis_tvalid & s_ready_s;

   // Next-state for the lane holding registers and pending mask.
   always_comb begin
      pending_d = pending_q;
      chan_d    = chan_q;
      time_d    = time_q;
      edge_d    = edge_q;
      if (s_hs_s) begin
         // An accepted beat replaces whatever was pending (at most the
         // lane being delivered in this same cycle).
         pending_d = s_axis_tkeep;
         chan_d    = s_axis_channel;
         time_d    = s_axis_tagtime;
         edge_d    = s_axis_rising_edge;
      end else if (m_hs_s) begin
         pending_d = pending_q & ~sel_mask_s;
      end else begin
         pending_d = pending_q;
      end
   end

   // Next-state for the delivered-tag counter and the ordering monitor.
   always_comb begin
      run_d        = 1'b1;
      count_d      = count_q;
      prev_time_d  = prev_time_q;
      prev_valid_d = prev_valid_q;
      order_err_d  = order_err_q;
      if (m_hs_s) begin
         count_d      = count_q + CNT_WIDTH'(1);
         prev_time_d  = sel_time_s;
         prev_valid_d = 1'b1;
         if (prev_valid_q && (sel_time_s < prev_time_q)) begin
            order_err_d = 1'b1;
         end else begin
            order_err_d = order_err_q;
         end
      end else begin
         count_d = count_q;
      end
   end

   // State registers; reset clears everything so all outputs read zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q    <= '0;
         chan_q       <= '0;
         time_q       <= '0;
         edge_q       <= '0;
         run_q        <= 1'b0;
         prev_time_q  <= 64'd0;
         prev_valid_q <= 1'b0;
         count_q      <= '0;
         order_err_q  <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         chan_q       <= chan_d;
         time_q       <= time_d;
         edge_q       <= edge_d;
         run_q        <= run_d;
         prev_time_q  <= prev_time_d;
         prev_valid_q <= prev_valid_d;
         count_q      <= count_d;
         order_err_q  <= order_err_d;
      end
   end

   assign s_axis_tready      = s_ready_s;
   assign m_axis_tvalid      = m_valid_s;
   assign m_axis_channel     = sel_ch_s;
   assign m_axis_tagtime     = sel_time_s;
   assign m_axis_rising_edge = sel_edge_s;
   assign m_axis_tlast       = m_last_s;
   assign tag_count          = count_q;
   assign order_error        = order_err_q;

endmodule

// File: tb/tb_si_tag_serializer.sv
// Self-checking bench for si_tag_serializer: a queue-based model of the
// tags still owed downstream is compared with the DUT every negedge, plus
// directed scenarios with hand-computed expectations.

module tb_si_tag_serializer;

   localparam int WW = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic [WW-1:0]   s_axis_tkeep = '0;
   logic [5*WW-1:0] s_axis_channel = '0;
   logic [64*WW-1:0] s_axis_tagtime = '0;
   logic [WW-1:0]   s_axis_rising_edge = '0;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b1;
   logic [4:0]      m_axis_channel;
   logic [63:0]     m_axis_tagtime;
   logic            m_axis_rising_edge;
   logic            m_axis_tlast;
   logic [CW-1:0]   tag_count;
   logic            order_error;

   si_tag_serializer #(.WORD_WIDTH(WW), .CNT_WIDTH(CW)) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_channel     (s_axis_channel),
      .s_axis_tagtime     (s_axis_tagtime),
      .s_axis_rising_edge (s_axis_rising_edge),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_channel     (m_axis_channel),
      .m_axis_tagtime     (m_axis_tagtime),
      .m_axis_rising_edge (m_axis_rising_edge),
      .m_axis_tlast       (m_axis_tlast),
      .tag_count          (tag_count),
      .order_error        (order_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0]  ch;
      logic [63:0] t;
      logic        e;
   } tag_t;

   tag_t        exp_q[$];
   logic        md_run = 1'b0;
   logic [CW-1:0] md_cnt = '0;
   logic [63:0] md_prev = 64'd0;
   logic        md_prev_v = 1'b0;
   logic        md_oerr = 1'b0;

   // log of DUT output handshakes for directed literal checks
   logic [63:0] log_t[$];
   logic [4:0]  log_ch[$];
   logic        log_last[$];

   // ready pattern: 0 = always ready, 1 = random 50%, 2 = never ready
   int rdy_mode = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Compare the DUT against the model, then advance the model through
   // the coming clock edge using the inputs that are now stable.
   initial begin
      tag_t tg;
      logic exp_v;
      logic exp_sr;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("rst_s_tready", 64'(s_axis_tready), 64'd0);
            check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_m_channel", 64'(m_axis_channel), 64'd0);
            check("rst_m_tagtime", m_axis_tagtime, 64'd0);
            check("rst_m_edge", 64'(m_axis_rising_edge), 64'd0);
            check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
            check("rst_tag_count", 64'(tag_count), 64'd0);
            check("rst_order_error", 64'(order_error), 64'd0);
            exp_q.delete();
            md_run    = 1'b0;
            md_cnt    = '0;
            md_prev   = 64'd0;
            md_prev_v = 1'b0;
            md_oerr   = 1'b0;
         end else begin
            exp_v  = (exp_q.size() != 0);
            exp_sr = md_run && ((exp_q.size() == 0) ||
                                (m_axis_tready && exp_q.size() == 1));
            check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
            check("m_tlast", 64'(m_axis_tlast), 64'(exp_q.size() == 1));
            check("s_tready", 64'(s_axis_tready), 64'(exp_sr));
            check("tag_count", 64'(tag_count), 64'(md_cnt));
            check("order_error", 64'(order_error), 64'(md_oerr));
            if (exp_v) begin
               check("m_channel", 64'(m_axis_channel), 64'(exp_q[0].ch));
               check("m_tagtime", m_axis_tagtime, exp_q[0].t);
               check("m_edge", 64'(m_axis_rising_edge), 64'(exp_q[0].e));
            end
            if (m_axis_tvalid && m_axis_tready) begin
               log_t.push_back(m_axis_tagtime);
               log_ch.push_back(m_axis_channel);
               log_last.push_back(m_axis_tlast);
            end
            if (exp_v && m_axis_tready) begin
               tg = exp_q.pop_front();
               md_cnt = md_cnt + 1;
               if (md_prev_v && (tg.t < md_prev)) md_oerr = 1'b1;
               md_prev   = tg.t;
               md_prev_v = 1'b1;
            end
            if (exp_sr && s_axis_tvalid) begin
               for (int i = 0; i < WW; i++) begin
                  if (s_axis_tkeep[i]) begin
                     tg.ch = s_axis_channel[i*5 +: 5];
                     tg.t  = s_axis_tagtime[i*64 +: 64];
                     tg.e  = s_axis_rising_edge[i];
                     exp_q.push_back(tg);
                  end
               end
            end
            md_run = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat until it is accepted; returns cycles it took.
   task automatic send_beat(input logic [WW-1:0] keep, input logic [5*WW-1:0] ch,
                            input logic [64*WW-1:0] t, input logic [WW-1:0] e,
                            output int cyc);
      logic hs;
      hs  = 1'b0;
      cyc = 0;
      s_axis_tvalid      = 1'b1;
      s_axis_tkeep       = keep;
      s_axis_channel     = ch;
      s_axis_tagtime     = t;
      s_axis_rising_edge = e;
      while (!hs && cyc < 200) begin
         @(negedge clk);
         hs = s_axis_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!hs) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_timeout: actual=no_accept required=accept");
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic clear_log();
      log_t.delete();
      log_ch.delete();
      log_last.delete();
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random scenarios ----------------
   initial begin
      int cyc;
      int sum;
      logic [CW-1:0] base;
      logic [64*WW-1:0] tv;
      logic [5*WW-1:0] cv;
      logic [63:0] exp_t[4];
      logic exp_l[4];

      rst = 1'b0;
      idle(3);
      check("reset_count_lit", 64'(tag_count), 64'd0);

      // 1: release and a full beat 10,20,30,40
      clear_log();
      rst = 1'b1;
      #1;
      check("first_cycle_tready", 64'(s_axis_tready), 64'd0);
      tv = {64'd40, 64'd30, 64'd20, 64'd10};
      cv = {5'd4, 5'd3, 5'd2, 5'd1};
      send_beat(4'b1111, cv, tv, 4'b0101, cyc);
      check("first_beat_cycles", 64'(cyc), 64'd2);
      idle(6);
      exp_t = '{64'd10, 64'd20, 64'd30, 64'd40};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      check("t1_log_size", 64'(log_t.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("t1_time", (i < log_t.size()) ? log_t[i] : 64'hx, exp_t[i]);
         check("t1_tlast", (i < log_last.size()) ? 64'(log_last[i]) : 64'hx, 64'(exp_l[i]));
      end
      check("t1_tag_count", 64'(tag_count), 64'd4);

      // 2: sparse, empty, single-lane beats
      clear_log();
      send_beat(4'b1010, {5'd7, 5'd0, 5'd2, 5'd0}, {64'd60, 64'd0, 64'd50, 64'd0}, 4'b1000, cyc);
      send_beat(4'b0000, {5'd31, 5'd31, 5'd31, 5'd31}, {64'd1, 64'd1, 64'd1, 64'd1}, 4'b1111, cyc);
      send_beat(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {64'd0, 64'd0, 64'd0, 64'd70}, 4'b0001, cyc);
      check("after_empty_cycles", 64'(cyc), 64'd1);
      idle(5);
      check("t2_log_size", 64'(log_ch.size()), 64'd3);
      check("t2_ch0", (log_ch.size() > 0) ? 64'(log_ch[0]) : 64'hx, 64'd2);
      check("t2_ch1", (log_ch.size() > 1) ? 64'(log_ch[1]) : 64'hx, 64'd7);
      check("t2_ch2", (log_ch.size() > 2) ? 64'(log_ch[2]) : 64'hx, 64'd9);
      check("t2_tag_count", 64'(tag_count), 64'd7);

      // 3: random backpressure, 1000 random full beats
      base = tag_count;
      rdy_mode = 1;
      for (int b = 0; b < 1000; b++) begin
         for (int i = 0; i < WW; i++) begin
            tv[i*64 +: 64] = {$urandom(), $urandom()};
            cv[i*5 +: 5]   = 5'($urandom_range(0, 31));
         end
         send_beat(4'b1111, cv, tv, 4'($urandom_range(0, 15)), cyc);
      end
      rdy_mode = 0;
      idle(10);
      check("t3_count_delta", 64'(tag_count - base), 64'd4000);

      // 4: back-to-back throughput
      idle(2);
      sum = 0;
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < WW; i++) tv[i*64 +: 64] = 64'(b * 4 + i);
         send_beat(4'b1111, cv, tv, 4'b0000, cyc);
         if (b > 0) sum += cyc;
      end
      check("t4_cycles_per_beat", 64'(sum), 64'd76);
      idle(6);

      // 5: ordering error
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(1);
      send_beat(4'b0011, cv, {64'd0, 64'd0, 64'd200, 64'd100}, 4'b0000, cyc);
      idle(4);
      check("t5_no_err_yet", 64'(order_error), 64'd0);
      send_beat(4'b0011, cv, {64'd0, 64'd0, 64'd150, 64'd150}, 4'b0000, cyc);
      check("t5_before_150_hs", 64'(order_error), 64'd0);
      idle(1);
      check("t5_at_150_hs", 64'(order_error), 64'd1);
      idle(4);
      check("t5_sticky", 64'(order_error), 64'd1);

      // 6: asynchronous reset with two lanes pending
      send_beat(4'b1111, cv, {64'd4, 64'd3, 64'd2, 64'd1}, 4'b0000, cyc);
      idle(2);
      rst = 1'b0;
      #1;
      check("t6_tvalid_now", 64'(m_axis_tvalid), 64'd0);
      check("t6_count_now", 64'(tag_count), 64'd0);
      idle(3);
      clear_log();
      rst = 1'b1;
      send_beat(4'b1111, cv, {64'd780, 64'd779, 64'd778, 64'd777}, 4'b0000, cyc);
      idle(6);
      check("t6_log_size", 64'(log_t.size()), 64'd4);
      check("t6_first_out", (log_t.size() > 0) ? log_t[0] : 64'hx, 64'd777);
      check("t6_tag_count", 64'(tag_count), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
